// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V sequencer: FETCH/DECODE/EXEC/MEM/WB, one datapath phase per clock.
// Latency R=4, load=5, store=4, branch=3, illegal=2 cycles; FETCH and MEM stall while mem_ready is low.
module multicycle_ctrl #(
  parameter int OPCODE_WIDTH = 7,
  parameter int ALU_OP_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    iord,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    reg_write,
  output logic                    memtoreg,
  output logic                    retire,
  output logic                    illegal,
  output logic [2:0]              state
);

  localparam logic [OPCODE_WIDTH-1:0] R_OPCODE = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] L_OPCODE = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] S_OPCODE = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] B_OPCODE = OPCODE_WIDTH'(7'b1100011);

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = ALU_OP_WIDTH'(2'b00);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = ALU_OP_WIDTH'(2'b01);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_FUNCT = ALU_OP_WIDTH'(2'b10);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    WB_MEM = 3'd6
  } state_t;

  state_t                  state_q;
  state_t                  state_nxt;
  logic [OPCODE_WIDTH-1:0] op_q;

  assign state = state_q;

  always_comb begin
    state_nxt = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    memtoreg  = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        // Branch target is computed here so EXEC only has to compare.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        if (opcode == R_OPCODE || opcode == L_OPCODE ||
            opcode == S_OPCODE || opcode == B_OPCODE) begin
          state_nxt = EXEC;
        end else begin
          illegal   = 1'b1;
          state_nxt = FETCH;
        end
      end
      EXEC: begin
        alu_src_a = 2'b01;
        case (op_q)
          R_OPCODE: begin
            alu_op    = ALU_FUNCT;
            state_nxt = WB;
          end
          L_OPCODE, S_OPCODE: begin
            alu_src_b = 2'b10;
            state_nxt = MEM;
          end
          B_OPCODE: begin
            alu_op    = ALU_SUB;
            pc_src    = 1'b1;
            pc_write  = zero;
            retire    = 1'b1;
            state_nxt = FETCH;
          end
          default: state_nxt = FETCH;
        endcase
      end
      MEM: begin
        iord = 1'b1;
        if (op_q == L_OPCODE) begin
          mem_read = 1'b1;
          if (mem_ready) state_nxt = WB_MEM;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            retire    = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      WB_MEM: begin
        reg_write = 1'b1;
        memtoreg  = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Opcode is captured in DECODE so later phases ignore IR changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == DECODE) op_q <= opcode;
    end
  end

endmodule
